// File: rtl/seq_alu_pkg.sv
// Shared types and saturation limits for the sequential ALU.
// Used by seq_alu and, when SEQ_ALU_MUL_EN is defined, by seq_alu_mul.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_NOR = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_LHB = 4'd7,
        OP_MUL = 4'd8
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    // Limits are returned zero-extended in 64 bits; callers size-cast to their width.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative signed shift-add multiplier, one multiplier bit per cycle,
// producing a 2*WIDTH product saturated to WIDTH bits. Built only with SEQ_ALU_MUL_EN.
module seq_alu_mul
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o,
    output logic             ov_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    logic signed [2*WIDTH-1:0] mcand_q;
    logic signed [2*WIDTH-1:0] acc_q;
    logic signed [2*WIDTH-1:0] addend;
    logic signed [2*WIDTH-1:0] acc_d;
    logic        [WIDTH-1:0]   mplier_q;
    logic        [CW-1:0]      cnt_q;
    logic                      busy_q;
    logic                      last;
    logic                      sat;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // The multiplier MSB carries negative weight, so the final step subtracts.
    always_comb begin
        addend = mplier_q[0] ? mcand_q : '0;
        acc_d  = last ? (acc_q - addend) : (acc_q + addend);
    end

    assign sat    = !((&acc_d[2*WIDTH-1:WIDTH-1]) || (~|acc_d[2*WIDTH-1:WIDTH-1]));
    assign ov_o   = sat;
    assign prod_o = sat ? (acc_d[2*WIDTH-1] ? MIN_V : MAX_V) : acc_d[WIDTH-1:0];
    assign done_o = busy_q && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            if (last) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            mcand_q  <= {{WIDTH{a_i[WIDTH-1]}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q <<< 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops with registered result and flags.
// Define SEQ_ALU_MUL_EN to add the iterative multiplier (opcode 8) and its busy state.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] dst,
    output logic             out_vld,
    output logic             ov,
    output logic             zr,
    output logic             neg
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

    function automatic logic [WIDTH-1:0] sat_lim(input logic to_min);
        return to_min ? MIN_V : MAX_V;
    endfunction

    logic signed [WIDTH-1:0] s0_s;
    logic signed [WIDTH-1:0] s1_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic        [WIDTH-1:0] alu_res;
    logic                    alu_ov;
    logic                    accept;
    logic                    mul_req;
    logic                    mul_done;
    logic        [WIDTH-1:0] mul_prod;
    logic                    mul_ov;

    logic [WIDTH-1:0] dst_q, dst_d;
    logic             vld_q, vld_d;
    logic             ov_q, ov_d;
    logic             zr_q, zr_d;
    logic             neg_q, neg_d;

    assign s0_s   = src0;
    assign s1_s   = src1;
    assign sum_s  = s0_s + s1_s;
    assign diff_s = s1_s - s0_s;
    assign accept = in_vld && in_rdy;

`ifdef SEQ_ALU_MUL_EN
    state_e state_q, state_d;

    assign mul_req = (func == OP_MUL);
    assign in_rdy  = (state_q == ST_IDLE);

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && mul_req),
        .a_i     (src0),
        .b_i     (src1),
        .done_o  (mul_done),
        .prod_o  (mul_prod),
        .ov_o    (mul_ov)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept && mul_req) state_d = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end
`else
    assign mul_req  = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
    assign mul_ov   = 1'b0;
    assign in_rdy   = 1'b1;
`endif

    // Reserved opcodes (and MUL when the multiplier is absent) fall to the zero default.
    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (func)
            OP_ADD: begin
                alu_ov  = (s0_s[WIDTH-1] == s1_s[WIDTH-1]) && (sum_s[WIDTH-1] != s0_s[WIDTH-1]);
                alu_res = alu_ov ? sat_lim(s0_s[WIDTH-1]) : sum_s;
            end
            OP_SUB: begin
                alu_ov  = (s1_s[WIDTH-1] != s0_s[WIDTH-1]) && (diff_s[WIDTH-1] != s1_s[WIDTH-1]);
                alu_res = alu_ov ? sat_lim(s1_s[WIDTH-1]) : diff_s;
            end
            OP_AND: alu_res = src0 & src1;
            OP_NOR: alu_res = ~(src0 | src1);
            OP_SLL: alu_res = src1 << shamt;
            OP_SRL: alu_res = src1 >> shamt;
            OP_SRA: alu_res = s1_s >>> shamt;
            OP_LHB: alu_res = {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]};
            default: begin
                alu_res = '0;
                alu_ov  = 1'b0;
            end
        endcase
    end

    always_comb begin
        dst_d = dst_q;
        ov_d  = ov_q;
        zr_d  = zr_q;
        neg_d = neg_q;
        vld_d = 1'b0;
        if (accept && !mul_req) begin
            dst_d = alu_res;
            ov_d  = alu_ov;
            zr_d  = ~|alu_res;
            neg_d = alu_res[WIDTH-1];
            vld_d = 1'b1;
        end else if (mul_done) begin
            dst_d = mul_prod;
            ov_d  = mul_ov;
            zr_d  = ~|mul_prod;
            neg_d = mul_prod[WIDTH-1];
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_q <= '0;
            vld_q <= 1'b0;
            ov_q  <= 1'b0;
            zr_q  <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            dst_q <= dst_d;
            vld_q <= vld_d;
            ov_q  <= ov_d;
            zr_q  <= zr_d;
            neg_q <= neg_d;
        end
    end

    assign dst     = dst_q;
    assign out_vld = vld_q;
    assign ov      = ov_q;
    assign zr      = zr_q;
    assign neg     = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16; multiplier cases follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld;
    logic             in_rdy;
    logic [3:0]       func;
    logic [WIDTH-1:0] src0;
    logic [WIDTH-1:0] src1;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] dst;
    logic             out_vld;
    logic             ov;
    logic             zr;
    logic             neg;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .func    (func),
        .src0    (src0),
        .src1    (src1),
        .shamt   (shamt),
        .dst     (dst),
        .out_vld (out_vld),
        .ov      (ov),
        .zr      (zr),
        .neg     (neg)
    );

    typedef struct {
        logic [3:0]  f;
        logic [15:0] s1;
        logic [15:0] s0;
        logic [3:0]  sh;
        logic [15:0] d;
        logic        ov;
        logic        zr;
        logic        ng;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] f, input logic [15:0] s1, input logic [15:0] s0,
                         input logic [3:0] sh);
        func   = f;
        src1   = s1;
        src0   = s0;
        shamt  = sh;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_vld(input int maxc, output bit got);
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_vld) got = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        bit seen;

        //           func   src1      src0      sh     dst       ov zr ng
        tbl[0]  = '{4'd0,  16'h7000, 16'h2000, 4'd0,  16'h7FFF, 1, 0, 0};
        tbl[1]  = '{4'd0,  16'hFFFE, 16'h0003, 4'd0,  16'h0001, 0, 0, 0};
        tbl[2]  = '{4'd0,  16'hFFFF, 16'h8000, 4'd0,  16'h8000, 1, 0, 1};
        tbl[3]  = '{4'd1,  16'h8000, 16'h0001, 4'd0,  16'h8000, 1, 0, 1};
        tbl[4]  = '{4'd1,  16'h0005, 16'h0007, 4'd0,  16'hFFFE, 0, 0, 1};
        tbl[5]  = '{4'd1,  16'h7FFF, 16'hFFFF, 4'd0,  16'h7FFF, 1, 0, 0};
        tbl[6]  = '{4'd2,  16'hFF00, 16'h00FF, 4'd0,  16'h0000, 0, 1, 0};
        tbl[7]  = '{4'd3,  16'h00F0, 16'h0F0F, 4'd0,  16'hF000, 0, 0, 1};
        tbl[8]  = '{4'd4,  16'h0001, 16'h0000, 4'd15, 16'h8000, 0, 0, 1};
        tbl[9]  = '{4'd5,  16'h8000, 16'h0000, 4'd15, 16'h0001, 0, 0, 0};
        tbl[10] = '{4'd6,  16'h8000, 16'h0000, 4'd15, 16'hFFFF, 0, 0, 1};
        tbl[11] = '{4'd6,  16'h4000, 16'h0000, 4'd0,  16'h4000, 0, 0, 0};
        tbl[12] = '{4'd5,  16'h1234, 16'h0000, 4'd4,  16'h0123, 0, 0, 0};
        tbl[13] = '{4'd7,  16'h12AB, 16'h34CD, 4'd0,  16'hABCD, 0, 0, 1};
        tbl[14] = '{4'd9,  16'h1234, 16'h5678, 4'd3,  16'h0000, 0, 1, 0};
        tbl[15] = '{4'd15, 16'hFFFF, 16'hFFFF, 4'd7,  16'h0000, 0, 1, 0};

        rst_n  = 1'b0;
        in_vld = 1'b0;
        func   = 4'd0;
        src0   = '0;
        src1   = '0;
        shamt  = '0;
        #3;
        chk("reset in_rdy", in_rdy, 1);
        chk("reset out_vld", out_vld, 0);
        chk("reset dst", dst, 0);
        chk("reset ov", ov, 0);
        chk("reset zr", zr, 0);
        chk("reset neg", neg, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].f, tbl[i].s1, tbl[i].s0, tbl[i].sh);
            chk($sformatf("v%0d out_vld", i), out_vld, 1);
            chk($sformatf("v%0d dst", i), dst, tbl[i].d);
            chk($sformatf("v%0d ov", i), ov, tbl[i].ov);
            chk($sformatf("v%0d zr", i), zr, tbl[i].zr);
            chk($sformatf("v%0d neg", i), neg, tbl[i].ng);
            chk($sformatf("v%0d in_rdy", i), in_rdy, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d vld drop", i), out_vld, 0);
            chk($sformatf("v%0d dst hold", i), dst, tbl[i].d);
            chk($sformatf("v%0d ov hold", i), ov, tbl[i].ov);
        end

        // Back-to-back ADD, SUB, AND
        func = 4'd0; src1 = 16'h0001; src0 = 16'h0002; shamt = '0; in_vld = 1'b1;
        @(posedge clk);
        #1;
        func = 4'd1; src1 = 16'h000A; src0 = 16'h0004;
        chk("b2b add vld", out_vld, 1);
        chk("b2b add dst", dst, 16'h0003);
        @(posedge clk);
        #1;
        func = 4'd2; src1 = 16'h0F0F; src0 = 16'h00FF;
        chk("b2b sub vld", out_vld, 1);
        chk("b2b sub dst", dst, 16'h0006);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        chk("b2b and vld", out_vld, 1);
        chk("b2b and dst", dst, 16'h000F);
        @(posedge clk);
        #1;
        chk("b2b end vld", out_vld, 0);

`ifdef SEQ_ALU_MUL_EN
        // -3 * 7 with in_vld held high on an ADD throughout the busy window
        issue(4'd8, 16'h0007, 16'hFFFD, 4'd0);
        func = 4'd0; src1 = 16'h0001; src0 = 16'h0001; in_vld = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("mul busy c%0d in_rdy", c), in_rdy, 0);
            chk($sformatf("mul busy c%0d out_vld", c), out_vld, 0);
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        chk("mul1 out_vld c17", out_vld, 1);
        chk("mul1 dst", dst, 16'hFFEB);
        chk("mul1 in_rdy c17", in_rdy, 1);
        chk("mul1 ov", ov, 0);
        chk("mul1 neg", neg, 1);
        @(posedge clk);
        #1;
        chk("mul1 vld drop", out_vld, 0);
        chk("mul1 dst hold", dst, 16'hFFEB);

        issue(4'd8, 16'hFFFF, 16'h8000, 4'd0);
        wait_vld(40, got);
        chk("mul2 done", got, 1);
        chk("mul2 dst", dst, 16'h7FFF);
        chk("mul2 ov", ov, 1);

        issue(4'd8, 16'hFF38, 16'h0064, 4'd0);
        wait_vld(40, got);
        chk("mul3 done", got, 1);
        chk("mul3 dst", dst, 16'hB1E0);
        chk("mul3 ov", ov, 0);
        chk("mul3 neg", neg, 1);

        // Reset in the middle of a multiply
        issue(4'd8, 16'h0003, 16'h0005, 4'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort dst", dst, 0);
        chk("abort in_rdy", in_rdy, 1);
        chk("abort out_vld", out_vld, 0);
        chk("abort zr", zr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_vld) seen = 1'b1;
        end
        chk("abort no pulse", seen, 0);
        chk("abort dst after", dst, 0);
        chk("abort in_rdy after", in_rdy, 1);
`else
        issue(4'd8, 16'h0007, 16'hFFFD, 4'd0);
        chk("op8 reserved vld", out_vld, 1);
        chk("op8 reserved dst", dst, 0);
        chk("op8 reserved zr", zr, 1);
        chk("op8 reserved ov", ov, 0);
        chk("op8 in_rdy", in_rdy, 1);

        issue(4'd0, 16'h1000, 16'h0234, 4'd0);
        chk("pre-reset dst", dst, 16'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset2 dst", dst, 0);
        chk("reset2 in_rdy", in_rdy, 1);
        chk("reset2 out_vld", out_vld, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_vld) seen = 1'b1;
        end
        chk("reset2 no pulse", seen, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
